seg_display_driver: RTL and testbench
=====================================

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning the number of clk cycles each digit stays selected (1 kHz at 100 MHz); legal range 2 and up.
REQ-002 SHALL have port clk, input, 1, the single system clock; all flops use its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port value, input, 7, unsigned binary count from the upstream counter (0..127; the counter saturates at 50).
REQ-005 SHALL have port blank, input, 1, forces all anodes off while high.
REQ-006 SHALL have port seg, output, 7, active-low segment lines; seg[6]=g through seg[0]=a.
REQ-007 SHALL have port an, output, 4, active-low one-hot digit anodes; an[0] is the ones digit.
REQ-008 SHALL have port busy, output, 1, high while a conversion is in progress.

Function
REQ-009 SHALL hold a 7-bit shadow of the last accepted value, plus three registered BCD display digits: hundreds, tens and ones.
REQ-010 SHALL run a conversion FSM with states IDLE, CONV and LOAD.
REQ-011 In IDLE, on the edge where value differs from the shadow: shadow <= value, load the shift register with value and zero BCD, iteration count <= 0, next state CONV.
REQ-012 In CONV, each edge SHALL perform one double-dabble step: add 3 to every BCD nibble that is >=5, then shift left one bit.
REQ-013 After exactly 7 CONV edges the FSM SHALL go to LOAD.
REQ-014 In LOAD, the display digits SHALL update from the BCD result on the next edge, and the FSM SHALL return to IDLE.
REQ-015 Latency: a change detected at edge N SHALL appear in the display digits after edge N+8.
REQ-016 busy SHALL be high after edge N through edge N+7, i.e. busy = (state != IDLE).
REQ-017 Changes on value outside IDLE SHALL be ignored. On return to IDLE the shadow compare repeats, so the final settled value is always displayed.
REQ-018 An equal value in IDLE SHALL start no conversion.
REQ-019 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap.
REQ-020 On each prescaler wrap, the digit select SHALL advance 0->1->2->0.
REQ-021 The select SHALL never take value 3, and an[3] SHALL be constantly 1.
REQ-022 an SHALL be the active-low one-hot of the digit select, except when blanked.
REQ-023 Blanking SHALL apply when blank=1 (an=4'b1111), when the hundreds digit is shown and equals 0, or when the tens digit is shown and both hundreds and tens equal 0.
REQ-024 The ones digit SHALL never be leading-zero blanked.
REQ-025 seg SHALL be the active-low encoding of the selected digit: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-026 seg SHALL be 7'h7F whenever the anodes are blanked.
REQ-027 seg and an SHALL be combinational from the registered select, digits and blank; no other combinational path from value to the outputs SHALL exist.

Reset
REQ-028 reset SHALL asynchronously clear: state=IDLE, shadow=0, digits=0/0/0, prescaler=0, select=0, iteration count=0.
REQ-029 During and after reset the outputs SHALL be an=4'b1110 (if blank=0), seg=7'h40 and busy=0.
REQ-030 Reset mid-conversion SHALL abort the conversion and discard the partial result.
REQ-031 After reset release, a nonzero value SHALL trigger conversion on the first edge.

Structure
REQ-032 Package seg_pkg SHALL hold the FSM state enum, the ten segment-pattern constants, SEG_BLANK=7'h7F and NUM_DIGITS=3.
REQ-033 The FSM, shadow and shift register SHALL live in the sub-module bin2bcd_seq (ports clk, reset, value, busy, hundreds, tens, ones).
REQ-034 The prescaler, digit select and segment decode SHALL live in the top level.

Verification (REFRESH_DIV=4)
REQ-035 Reset, then value=0 held -> busy never rises; an cycles 1110 only, with tens and hundreds slots blanked (1111); seg=7'h40 on the ones slot.
REQ-036 value 0->50 at edge N -> busy high over N+1..N+7; digits 0/5/0 after N+8; tens slot seg=7'h12, ones slot seg=7'h40, hundreds slot blanked.
REQ-037 value=127 -> hundreds slot seg=7'h79, tens slot seg=7'h24, ones slot seg=7'h78.
REQ-038 value 7->8 and then 8->9 two cycles apart -> one conversion to 8, then a second starting on the first IDLE edge; final digits 0/0/9.
REQ-039 Assert reset at the 4th CONV cycle of value=99 -> digits 0/0/0, busy=0, an=4'b1110; after release a new conversion yields 0/9/9.
REQ-040 blank=1 for 20 cycles with value=42 -> an=4'b1111 and seg=7'h7F throughout; the select keeps advancing and the display resumes in phase.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg_pkg
// Purpose : Shared types and seven-segment constants for the display driver.
// Revision: 1.0 - initial release
// ============================================================================
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } conv_state_t;

    localparam int unsigned NUM_DIGITS = 3;

    // Active-low patterns, bit 6 = g ... bit 0 = a
    localparam logic [6:0] SEG_DIGIT_0 = 7'h40;
    localparam logic [6:0] SEG_DIGIT_1 = 7'h79;
    localparam logic [6:0] SEG_DIGIT_2 = 7'h24;
    localparam logic [6:0] SEG_DIGIT_3 = 7'h30;
    localparam logic [6:0] SEG_DIGIT_4 = 7'h19;
    localparam logic [6:0] SEG_DIGIT_5 = 7'h12;
    localparam logic [6:0] SEG_DIGIT_6 = 7'h02;
    localparam logic [6:0] SEG_DIGIT_7 = 7'h78;
    localparam logic [6:0] SEG_DIGIT_8 = 7'h00;
    localparam logic [6:0] SEG_DIGIT_9 = 7'h10;
    localparam logic [6:0] SEG_BLANK   = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        pattern = SEG_BLANK;
        case (digit)
            4'd0:    pattern = SEG_DIGIT_0;
            4'd1:    pattern = SEG_DIGIT_1;
            4'd2:    pattern = SEG_DIGIT_2;
            4'd3:    pattern = SEG_DIGIT_3;
            4'd4:    pattern = SEG_DIGIT_4;
            4'd5:    pattern = SEG_DIGIT_5;
            4'd6:    pattern = SEG_DIGIT_6;
            4'd7:    pattern = SEG_DIGIT_7;
            4'd8:    pattern = SEG_DIGIT_8;
            4'd9:    pattern = SEG_DIGIT_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq
// Purpose : Change-triggered sequential double-dabble, 7-bit binary to 3 BCD digits.
// Revision: 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] value,
    output logic       busy,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    conv_state_t r_state;
    conv_state_t w_state_next;

    logic [6:0]  r_shadow;
    logic [18:0] r_shift;      // {hundreds, tens, ones, binary}
    logic [2:0]  r_iter;
    logic [3:0]  r_hundreds;
    logic [3:0]  r_tens;
    logic [3:0]  r_ones;

    function automatic logic [18:0] dd_step(input logic [18:0] sr);
        logic [18:0] adj;
        adj = sr;
        for (int i = 0; i < 3; i++) begin
            if (adj[7 + 4*i +: 4] >= 4'd5) begin
                adj[7 + 4*i +: 4] = adj[7 + 4*i +: 4] + 4'd3;
            end
        end
        return {adj[17:0], 1'b0};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (value != r_shadow) w_state_next = ST_CONV;
            ST_CONV: if (r_iter == 3'd6)    w_state_next = ST_LOAD;
            ST_LOAD: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow   <= 7'd0;
            r_shift    <= 19'd0;
            r_iter     <= 3'd0;
            r_hundreds <= 4'd0;
            r_tens     <= 4'd0;
            r_ones     <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (value != r_shadow) begin
                        r_shadow <= value;
                        r_shift  <= {12'd0, value};
                        r_iter   <= 3'd0;
                    end
                end
                ST_CONV: begin
                    r_shift <= dd_step(r_shift);
                    r_iter  <= r_iter + 3'd1;
                end
                ST_LOAD: begin
                    r_hundreds <= r_shift[18:15];
                    r_tens     <= r_shift[14:11];
                    r_ones     <= r_shift[10:7];
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign hundreds = r_hundreds;
    assign tens     = r_tens;
    assign ones     = r_ones;

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module  : seg_display_driver
// Purpose : Multiplexed 3-digit seven-segment driver with leading-zero blanking.
// Revision: 1.0 - initial release
// ============================================================================
module seg_display_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] value,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PRESC_W-1:0] r_presc;
    logic [1:0]         r_sel;
    logic [3:0]         w_hundreds;
    logic [3:0]         w_tens;
    logic [3:0]         w_ones;
    logic [3:0]         w_digit;
    logic               w_blanked;

    bin2bcd_seq u_bin2bcd (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .busy     (busy),
        .hundreds (w_hundreds),
        .tens     (w_tens),
        .ones     (w_ones)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_sel   <= 2'd0;
        end else if (r_presc == PRESC_W'(REFRESH_DIV - 1)) begin
            r_presc <= '0;
            r_sel   <= (r_sel == 2'(NUM_DIGITS - 1)) ? 2'd0 : r_sel + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Ones is never leading-zero blanked so a value of 0 still shows "0"
    always_comb begin
        w_digit   = w_ones;
        w_blanked = blank;
        case (r_sel)
            2'd1: begin
                w_digit   = w_tens;
                w_blanked = blank || ((w_hundreds == 4'd0) && (w_tens == 4'd0));
            end
            2'd2: begin
                w_digit   = w_hundreds;
                w_blanked = blank || (w_hundreds == 4'd0);
            end
            default: ;
        endcase
    end

    assign an  = w_blanked ? 4'b1111   : ~(4'b0001 << r_sel);
    assign seg = w_blanked ? SEG_BLANK : seg_decode(w_digit);

endmodule : seg_display_driver
`default_nettype wire

// File: tb/tb_seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_display_driver
// Purpose : Self-checking bench for seg_display_driver against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg_display_driver;

    localparam int REFRESH_DIV = 4;
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] value = 7'd0;
    logic       blank = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Behavioural model: conversion occupies 8 cycles, display is decimal of the settled value
    int m_shadow, m_cnt, m_pending, m_disp, m_presc, m_sel;

    seg_display_driver #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .blank (blank),
        .seg   (seg),
        .an    (an),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_shadow = 0; m_cnt = 0; m_pending = 0; m_disp = 0; m_presc = 0; m_sel = 0;
    endtask

    task automatic model_update();
        if (m_presc == REFRESH_DIV - 1) begin
            m_presc = 0;
            m_sel   = (m_sel + 1) % 3;
        end else begin
            m_presc++;
        end
        if (m_cnt == 0) begin
            if (int'(value) != m_shadow) begin
                m_shadow  = int'(value);
                m_pending = int'(value);
                m_cnt     = 8;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) m_disp = m_pending;
        end
    endtask

    function automatic bit exp_blanked();
        int h = m_disp / 100;
        int t = (m_disp / 10) % 10;
        return blank || (m_sel == 2 && h == 0) || (m_sel == 1 && h == 0 && t == 0);
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] onehot;
        onehot = 4'b0001 << m_sel;
        return exp_blanked() ? 4'b1111 : ~onehot;
    endfunction

    function automatic logic [6:0] exp_seg();
        int d;
        if (exp_blanked()) return 7'h7F;
        case (m_sel)
            0:       d = m_disp % 10;
            1:       d = (m_disp / 10) % 10;
            default: d = m_disp / 100;
        endcase
        return SEG_TAB[d];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset) model_update();
        #1;
    endtask

    task automatic test_reset();
        value = 7'd0; blank = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            checks += 3;
            if (an !== 4'b1110) begin errors++; $display("FAIL reset_an: got %b want 1110", an); end
            if (seg !== 7'h40)  begin errors++; $display("FAIL reset_seg: got %h want 40", seg); end
            if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_zero_hold();
        value = 7'd0;
        for (int i = 0; i < 24; i++) begin
            tick();
            checks += 3;
            if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
            if (an !== exp_an()) begin errors++; $display("FAIL zero_an: got %b want %b", an, exp_an()); end
            if (seg !== exp_seg()) begin errors++; $display("FAIL zero_seg: got %h want %h", seg, exp_seg()); end
        end
    endtask

    task automatic test_fifty();
        value = 7'd50;
        for (int i = 0; i <= 8; i++) begin
            tick();
            checks++;
            if (busy !== (i < 8)) begin
                errors++; $display("FAIL fifty_busy_%0d: got %b want %b", i, busy, (i < 8));
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks += 3;
            if (an !== exp_an()) begin errors++; $display("FAIL fifty_an: got %b want %b", an, exp_an()); end
            if (an == 4'b1101 && seg !== 7'h12) begin errors++; $display("FAIL fifty_tens: got %h want 12", seg); end
            if (an == 4'b1110 && seg !== 7'h40) begin errors++; $display("FAIL fifty_ones: got %h want 40", seg); end
        end
    endtask

    task automatic test_127();
        int seen;
        seen  = 0;
        value = 7'd127;
        for (int i = 0; i < 9; i++) tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            checks += 2;
            if (seg !== exp_seg()) begin errors++; $display("FAIL max_seg: got %h want %h", seg, exp_seg()); end
            case (an)
                4'b1011: begin seen |= 4; if (seg !== 7'h79) begin errors++; $display("FAIL max_hund: got %h want 79", seg); end end
                4'b1101: begin seen |= 2; if (seg !== 7'h24) begin errors++; $display("FAIL max_tens: got %h want 24", seg); end end
                4'b1110: begin seen |= 1; if (seg !== 7'h78) begin errors++; $display("FAIL max_ones: got %h want 78", seg); end end
                default: begin errors++; $display("FAIL max_an: got %b want one-hot low", an); end
            endcase
        end
        checks++;
        if (seen != 7) begin errors++; $display("FAIL max_slots: got %0d want 7", seen); end
    endtask

    task automatic test_back_to_back();
        int rises;
        logic prev_busy;
        value = 7'd7;
        for (int i = 0; i < 12; i++) tick();
        rises = 0; prev_busy = busy;
        value = 7'd8;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 1) value = 7'd9;
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
            checks += 3;
            if (busy !== (m_cnt != 0)) begin errors++; $display("FAIL b2b_busy_%0d: got %b want %b", i, busy, (m_cnt != 0)); end
            if (an !== exp_an()) begin errors++; $display("FAIL b2b_an: got %b want %b", an, exp_an()); end
            if (seg !== exp_seg()) begin errors++; $display("FAIL b2b_seg: got %h want %h", seg, exp_seg()); end
        end
        checks += 2;
        if (rises != 2) begin errors++; $display("FAIL b2b_conversions: got %0d want 2", rises); end
        if (m_disp != 9) begin errors++; $display("FAIL b2b_model_final: got %0d want 9", m_disp); end
    endtask

    task automatic test_reset_mid();
        value = 7'd99;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        #1;
        model_reset();
        checks += 3;
        if (busy !== 1'b0)  begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (an !== 4'b1110) begin errors++; $display("FAIL abort_an: got %b want 1110", an); end
        if (seg !== 7'h40)  begin errors++; $display("FAIL abort_seg: got %h want 40", seg); end
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b want 1", busy); end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks += 3;
            if (busy !== (m_cnt != 0)) begin errors++; $display("FAIL restart_busy_%0d: got %b want %b", i, busy, (m_cnt != 0)); end
            if (an !== exp_an()) begin errors++; $display("FAIL restart_an: got %b want %b", an, exp_an()); end
            if (seg !== exp_seg()) begin errors++; $display("FAIL restart_seg: got %h want %h", seg, exp_seg()); end
        end
    endtask

    task automatic test_blank();
        value = 7'd42;
        for (int i = 0; i < 10; i++) tick();
        blank = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks += 2;
            if (an !== 4'b1111) begin errors++; $display("FAIL blank_an: got %b want 1111", an); end
            if (seg !== 7'h7F)  begin errors++; $display("FAIL blank_seg: got %h want 7f", seg); end
        end
        blank = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) begin
            checks += 2;
            if (an !== exp_an()) begin errors++; $display("FAIL unblank_an: got %b want %b", an, exp_an()); end
            if (seg !== exp_seg()) begin errors++; $display("FAIL unblank_seg: got %h want %h", seg, exp_seg()); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) value = 7'($urandom_range(0, 127));
            blank = ($urandom_range(0, 15) == 0);
            tick();
            checks += 3;
            if (busy !== (m_cnt != 0)) begin errors++; $display("FAIL rand_busy: got %b want %b", busy, (m_cnt != 0)); end
            if (an !== exp_an()) begin errors++; $display("FAIL rand_an: got %b want %b (val %0d)", an, exp_an(), m_disp); end
            if (seg !== exp_seg()) begin errors++; $display("FAIL rand_seg: got %h want %h (val %0d)", seg, exp_seg(), m_disp); end
        end
        blank = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        test_reset();
        test_zero_hold();
        test_fifty();
        test_127();
        test_back_to_back();
        test_reset_mid();
        test_blank();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seg_display_driver
`default_nettype wire
